shift_transmitter: RTL

- Parallel-to-serial transmitter. It is the sending end of the shifted-word link whose receiver counts shift_clk rising edges and holds each completed word.
- Accepts an N-bit word through a valid/ready handshake, then generates the shift clock from sync_clk.
- Shifts the word out MSB first, one bit per shift_clk period, for NUM_SHIFTS periods.
- Ends each frame with a frame_done pulse and an idle gap.

---
 rtl/shift_transmitter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_transmitter.sv
// shift_transmitter: parallel-to-serial sender, MSB first, with a generated shift clock.
// Each frame: handshake accept, NUM_SHIFTS shift_clk periods, then a GAP-cycle idle gap.
module shift_transmitter #(
    parameter int N          = 11,
    parameter int NUM_SHIFTS = 11,
    parameter int CLK_DIV    = 2,
    parameter int GAP        = 2
) (
    input  logic         sync_clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         shift_clk,
    output logic         serial_out,
    output logic         busy,
    output logic         frame_done
);
    localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(NUM_SHIFTS + 1);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sh_q, sh_d;
    logic [HW-1:0]  hc_q, hc_d;
    logic [SW-1:0]  sc_q, sc_d;
    logic [GW-1:0]  gc_q, gc_d;
    logic           shift_clk_q, shift_clk_d;
    logic           serial_out_q, serial_out_d;
    logic           load_ready_q, load_ready_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        hc_d         = hc_q;
        sc_d         = sc_q;
        gc_d         = gc_q;
        shift_clk_d  = shift_clk_q;
        serial_out_d = serial_out_q;
        load_ready_d = load_ready_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: if (load_valid && load_ready_q) begin
                state_d      = SHIFT;
                sh_d         = in_data;
                serial_out_d = in_data[N-1];
                load_ready_d = 1'b0;
                busy_d       = 1'b1;
                hc_d         = '0;
                sc_d         = '0;
                shift_clk_d  = 1'b0;
            end
            SHIFT: if (hc_q != HW'(CLK_DIV - 1)) begin
                hc_d = hc_q + 1'b1;
            end else begin
                hc_d = '0;
                // a half-period ends: rise, finish the frame, or fall and advance the bit
                if (!shift_clk_q) begin
                    shift_clk_d = 1'b1;
                    sc_d        = sc_q + 1'b1;
                end else if (sc_q == SW'(NUM_SHIFTS)) begin
                    state_d      = DONE;
                    shift_clk_d  = 1'b0;
                    serial_out_d = 1'b1;
                    frame_done_d = 1'b1;
                    gc_d         = '0;
                end else begin
                    shift_clk_d  = 1'b0;
                    sh_d         = (sh_q << 1) | N'(1);
                    serial_out_d = sh_d[N-1];
                end
            end
            DONE: if (gc_q == GW'(GAP - 1)) begin
                state_d      = IDLE;
                load_ready_d = 1'b1;
                busy_d       = 1'b0;
            end else begin
                gc_d = gc_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sync_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            hc_q         <= '0;
            sc_q         <= '0;
            gc_q         <= '0;
            shift_clk_q  <= 1'b0;
            serial_out_q <= 1'b1;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            hc_q         <= hc_d;
            sc_q         <= sc_d;
            gc_q         <= gc_d;
            shift_clk_q  <= shift_clk_d;
            serial_out_q <= serial_out_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign shift_clk  = shift_clk_q;
    assign serial_out = serial_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
endmodule
